// File: rtl/nand3_bist_seq.sv
// nand3_bist_seq
// Built-in self-test sequencer for a single NAND3X1 cell. It sweeps the
// cell's A/B/C pins through an 8-vector Gray sequence, so every step toggles
// exactly one input. Each vector is held SETTLE cycles, Y is sampled on the
// final edge of that window and compared with the ideal NAND3 value, and a
// saturating mismatch count plus a pass/fail flag are reported.
//
// Parameters:
//   SETTLE  cycles each vector is held before Y is sampled (1..255)
//   PASSES  full 8-vector sweeps per run (1..255)
//   ERR_W   width of the mismatch counter
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   start        launches a run when sampled high in IDLE
//   abort        ends a run early (ignored in IDLE; wins over start)
//   dut_y        Y output of the cell under test
//   dut_a/b/c    registered drive to the cell's A/B/C pins
//   busy         high while a run is in progress
//   done         one-cycle pulse at the end of a run
//   pass         result of the last run, valid from done until next start
//   err_cnt      mismatch count, saturates at all-ones
//   vec_idx      sweep index 0..7 of the vector currently driven
//   state_dbg    current FSM state (debug)
//
// Optional feature (macro NAND3_BIST_FAILLOG_EN):
//   fail_vec     {c,b,a} vector of the first mismatch in the run
//   fail_valid   high once fail_vec holds a captured vector
//
// Handshake: start and abort are level-sampled single-cycle requests; there
// is no ready signal. start is only honoured in IDLE, abort only in RUN, and
// an accepted request takes effect at the edge that samples it.

module nand3_bist_seq #(
  parameter int SETTLE = 4,
  parameter int PASSES = 2,
  parameter int ERR_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             dut_y,
  output logic             dut_a,
  output logic             dut_b,
  output logic             dut_c,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [2:0]       vec_idx,
  output logic [1:0]       state_dbg
`ifdef NAND3_BIST_FAILLOG_EN
  ,
  output logic [2:0]       fail_vec,
  output logic             fail_valid
`endif
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [7:0]       SETTLE_RELOAD = 8'(SETTLE - 1);
  localparam logic [7:0]       LAST_PASS     = 8'(PASSES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX       = '1;

  logic [1:0]       state;
  logic [7:0]       settle_cnt;
  logic [7:0]       pass_cnt;

  logic [2:0]       pins;
  logic             mismatch;
  logic [ERR_W-1:0] err_next;
  logic [2:0]       idx_next;
  logic             last_sample;

  // Sweep index to pin vector {c,b,a}: binary-reflected Gray code.
  function automatic logic [2:0] gray3(input logic [2:0] i);
    return i ^ (i >> 1);
  endfunction

  assign state_dbg   = state;
  assign pins        = {dut_c, dut_b, dut_a};
  assign mismatch    = (dut_y != ~(&pins));
  assign err_next    = (mismatch && (err_cnt != ERR_MAX)) ? err_cnt + 1'b1 : err_cnt;
  assign idx_next    = vec_idx + 3'd1;
  assign last_sample = (vec_idx == 3'd7) && (pass_cnt == LAST_PASS);

  always_ff @(posedge clk) begin
    if (reset) begin
      state                 <= ST_IDLE;
      settle_cnt            <= '0;
      pass_cnt              <= '0;
      {dut_c, dut_b, dut_a} <= 3'b000;
      busy                  <= 1'b0;
      done                  <= 1'b0;
      pass                  <= 1'b0;
      err_cnt               <= '0;
      vec_idx               <= 3'd0;
`ifdef NAND3_BIST_FAILLOG_EN
      fail_vec              <= 3'b000;
      fail_valid            <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state                 <= ST_RUN;
            err_cnt               <= '0;
            pass                  <= 1'b0;
            vec_idx               <= 3'd0;
            {dut_c, dut_b, dut_a} <= 3'b000;
            settle_cnt            <= SETTLE_RELOAD;
            pass_cnt              <= '0;
            busy                  <= 1'b1;
`ifdef NAND3_BIST_FAILLOG_EN
            fail_vec              <= 3'b000;
            fail_valid            <= 1'b0;
`endif
          end
        end

        ST_RUN: begin
          if (abort) begin
            // No sample on the abort edge; err_cnt keeps its value.
            state                 <= ST_DONE;
            pass                  <= 1'b0;
            {dut_c, dut_b, dut_a} <= 3'b000;
            vec_idx               <= 3'd0;
            busy                  <= 1'b0;
            done                  <= 1'b1;
          end else if (settle_cnt != 8'd0) begin
            settle_cnt <= settle_cnt - 8'd1;
          end else begin
            // Sample edge: score Y against the vector held this window.
            err_cnt <= err_next;
`ifdef NAND3_BIST_FAILLOG_EN
            if (mismatch && !fail_valid) begin
              fail_vec   <= pins;
              fail_valid <= 1'b1;
            end
`endif
            if (last_sample) begin
              state                 <= ST_DONE;
              pass                  <= (err_next == '0);
              {dut_c, dut_b, dut_a} <= 3'b000;
              vec_idx               <= 3'd0;
              busy                  <= 1'b0;
              done                  <= 1'b1;
            end else begin
              vec_idx               <= idx_next;
              {dut_c, dut_b, dut_a} <= gray3(idx_next);
              settle_cnt            <= SETTLE_RELOAD;
              if (vec_idx == 3'd7) begin
                pass_cnt <= pass_cnt + 8'd1;
              end
            end
          end
        end

        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nand3_bist_seq.sv
// tb_nand3_bist_seq
// Self-checking bench for nand3_bist_seq. Two instances share stimulus: one
// with default parameters and one with a 2-bit error counter to exercise
// saturation. The reference model is a lookup table of the sweep order and
// the timing rule "vector k is held for SETTLE cycles after the start edge,
// Y is sampled on the last edge of each window".

module tb_nand3_bist_seq;

  localparam int S     = 4;
  localparam int P     = 2;
  localparam int TOTAL = 8 * P * S;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic dut_y = 1'b1;

  logic       a1, b1, c1, busy1, done1, pass1;
  logic [7:0] err1;
  logic [2:0] idx1;
  logic [1:0] st1;
  logic       a2, b2, c2, busy2, done2, pass2;
  logic [1:0] err2;
  logic [2:0] idx2;
  logic [1:0] st2;
`ifdef NAND3_BIST_FAILLOG_EN
  logic [2:0] fvec1, fvec2;
  logic       fval1, fval2;
`endif

  nand3_bist_seq #(.SETTLE(S), .PASSES(P), .ERR_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .dut_y(dut_y),
    .dut_a(a1), .dut_b(b1), .dut_c(c1), .busy(busy1), .done(done1),
    .pass(pass1), .err_cnt(err1), .vec_idx(idx1), .state_dbg(st1)
`ifdef NAND3_BIST_FAILLOG_EN
    , .fail_vec(fvec1), .fail_valid(fval1)
`endif
  );

  nand3_bist_seq #(.SETTLE(S), .PASSES(P), .ERR_W(2)) dut_sat (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .dut_y(dut_y),
    .dut_a(a2), .dut_b(b2), .dut_c(c2), .busy(busy2), .done(done2),
    .pass(pass2), .err_cnt(err2), .vec_idx(idx2), .state_dbg(st2)
`ifdef NAND3_BIST_FAILLOG_EN
    , .fail_vec(fvec2), .fail_valid(fval2)
`endif
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [2:0] vec_tab [8];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_pins"}, {29'd0, c1, b1, a1}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy1}, 32'd0);
    check({tag, "_done"}, {31'd0, done1}, 32'd0);
    check({tag, "_pass"}, {31'd0, pass1}, 32'd0);
    check({tag, "_err"}, {24'd0, err1}, 32'd0);
    check({tag, "_idx"}, {29'd0, idx1}, 32'd0);
    check({tag, "_err_sat"}, {30'd0, err2}, 32'd0);
    check({tag, "_pins_sat"}, {29'd0, c2, b2, a2}, 32'd0);
`ifdef NAND3_BIST_FAILLOG_EN
    check({tag, "_fvalid"}, {31'd0, fval1}, 32'd0);
    check({tag, "_fvec"}, {29'd0, fvec1}, 32'd0);
`endif
  endtask

  // Y source for interval j after the start edge.
  // mode 0 ideal, 1 stuck-at-1, 2 stuck-at-0, 3 ideal delayed 5 cycles, 4 random.
  function automatic logic y_for(input int mode, input int j);
    logic [2:0] v;
    v = vec_tab[(j / S) % 8];
    case (mode)
      0: return ~(&v);
      1: return 1'b1;
      2: return 1'b0;
      3: return (j >= 5) ? ~(&vec_tab[((j - 5) / S) % 8]) : 1'b1;
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  // One run: start pulse, per-interval pin checks, result checks at done.
  // abort_at < 0 (or beyond the run) means no abort; glitch_at is an
  // interval where start is raised mid-run; start_in_done raises start in
  // the done cycle. exp_raw < 0 skips the fixed expected-count check.
  task automatic run_one(input string tag, input int mode, input int abort_at,
                         input int glitch_at, input bit start_in_done, input int exp_raw);
    int raw;
    int end_j;
    bit aborted;
    logic y;
    logic [2:0] v;
    logic [2:0] first_fail;
    bit has_fail;
    raw = 0;
    has_fail = 1'b0;
    first_fail = 3'b000;
    aborted = (abort_at >= 0) && (abort_at < TOTAL);
    end_j = aborted ? abort_at + 1 : TOTAL;

    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int j = 0; j < end_j; j++) begin
      v = vec_tab[(j / S) % 8];
      check({tag, "_pins"}, {29'd0, c1, b1, a1}, {29'd0, v});
      check({tag, "_idx"}, {29'd0, idx1}, 32'((j / S) % 8));
      check({tag, "_busy"}, {31'd0, busy1}, 32'd1);
      check({tag, "_done_low"}, {31'd0, done1}, 32'd0);
      y = y_for(mode, j);
      dut_y = y;
      if ((((j + 1) % S) == 0) && !(aborted && j == abort_at)) begin
        if (y != ~(&v)) begin
          raw++;
          if (!has_fail) begin
            has_fail = 1'b1;
            first_fail = v;
          end
        end
      end
      abort = aborted && (j == abort_at);
      start = (j == glitch_at);
      @(negedge clk);
    end
    abort = 1'b0;
    start = start_in_done;

    if (exp_raw >= 0) check({tag, "_raw_model"}, 32'(raw), 32'(exp_raw));
    check({tag, "_done"}, {31'd0, done1}, 32'd1);
    check({tag, "_busy_end"}, {31'd0, busy1}, 32'd0);
    check({tag, "_pins_end"}, {29'd0, c1, b1, a1}, 32'd0);
    check({tag, "_pass"}, {31'd0, pass1}, (aborted || raw != 0) ? 32'd0 : 32'd1);
    check({tag, "_err"}, {24'd0, err1}, 32'((raw > 255) ? 255 : raw));
    check({tag, "_done_sat"}, {31'd0, done2}, 32'd1);
    check({tag, "_pass_sat"}, {31'd0, pass2}, (aborted || raw != 0) ? 32'd0 : 32'd1);
    check({tag, "_err_sat"}, {30'd0, err2}, 32'((raw > 3) ? 3 : raw));
`ifdef NAND3_BIST_FAILLOG_EN
    check({tag, "_fvalid"}, {31'd0, fval1}, {31'd0, has_fail});
    check({tag, "_fvec"}, {29'd0, fvec1}, {29'd0, first_fail});
`endif
    @(negedge clk);
    start = 1'b0;
    check({tag, "_done_gone"}, {31'd0, done1}, 32'd0);
    check({tag, "_idle_busy"}, {31'd0, busy1}, 32'd0);
    check({tag, "_pass_hold"}, {31'd0, pass1}, (aborted || raw != 0) ? 32'd0 : 32'd1);
    check({tag, "_err_hold"}, {24'd0, err1}, 32'((raw > 255) ? 255 : raw));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    vec_tab = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};

    repeat (2) @(negedge clk);
    check_reset_values("reset");
    reset = 1'b0;
    @(negedge clk);

    run_one("ideal", 0, -1, -1, 1'b0, 0);
    run_one("stuck1", 1, -1, -1, 1'b0, 2);
    run_one("delay5", 3, -1, -1, 1'b0, 4);
    run_one("stuck0", 2, -1, -1, 1'b0, 14);
    run_one("abort10", 2, 10, -1, 1'b0, 2);
    run_one("glitch", 1, -1, 21, 1'b1, 2);
    run_one("abort_start", 0, 30, 30, 1'b0, 0);

    for (int r = 0; r < 6; r++) begin
      int mode;
      int ab;
      mode = $urandom_range(0, 4);
      ab = ($urandom_range(0, 1) != 0) ? $urandom_range(0, TOTAL - 1) : -1;
      run_one($sformatf("rand%0d", r), mode, ab, $urandom_range(0, TOTAL - 1),
              1'($urandom_range(0, 1)), -1);
    end

    // Reset in the middle of a failing run, then a clean run.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int j = 0; j < 23; j++) begin
      dut_y = 1'b0;
      @(negedge clk);
    end
    reset = 1'b1;
    @(negedge clk);
    check_reset_values("midreset");
    reset = 1'b0;
    dut_y = 1'b1;
    @(negedge clk);
    run_one("after_reset", 0, -1, -1, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
